// File: rtl/spi_mem_pkg.sv
// Shared constants, state encoding and frame builder for the SPI SRAM bridge.
// A frame is a command byte, a 24-bit address and one data byte, sent MSB first.
package spi_mem_pkg;

   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam int         FRAME_BITS = 40;
   localparam int         ADDR_BITS  = 24;
   localparam int         BIT_CNT_W  = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_e;

   // Reads carry a zero data byte; the SRAM drives MISO during that byte.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic                 rd,
      input logic [ADDR_BITS-1:0] addr,
      input logic [7:0]           data
   );
      return {(rd ? CMD_READ : CMD_WRITE), addr, (rd ? 8'h00 : data)};
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period tick generator. The counter sits at zero while disabled,
// so the first tick after enable arrives exactly CLK_DIV cycles later.
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CNT_W    = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick_o = en_i && (cnt_q == CNT_LAST);
      cnt_d  = cnt_q;
      if (!en_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_mem_bridge.sv
// Turns single-cycle read/write requests into one mode-0 SPI frame to an
// external SRAM, returning read data and a one-cycle completion pulse.
module spi_mem_bridge
   import spi_mem_pkg::*;
#(
   parameter int ADDR_WIDTH_EXT = 20,
   parameter int DATA_WIDTH     = 8,
   parameter int CLK_DIV        = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      spi_we,
   input  logic                      spi_re,
   input  logic [ADDR_WIDTH_EXT-1:0] spi_addr,
   input  logic [DATA_WIDTH-1:0]     spi_din,
   output logic [DATA_WIDTH-1:0]     spi_dout,
   output logic                      spi_busy,
   output logic                      spi_done,
   output logic                      sclk,
   output logic                      cs_n,
   output logic                      mosi,
   input  logic                      miso
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   state_e                  state_q, state_d;
   logic [FRAME_BITS-1:0]   tx_q, tx_d;
   logic [DATA_WIDTH-1:0]   rx_q, rx_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic [BIT_CNT_W-1:0]    bit_q, bit_d;
   logic                    rd_q, rd_d;
   logic                    sclk_q, sclk_d;
   logic                    frame_active;
   logic                    tick;
   logic [ADDR_BITS-1:0]    addr_ext;

   assign frame_active = (state_q == SETUP) || (state_q == SHIFT);
   assign addr_ext     = {{(ADDR_BITS - ADDR_WIDTH_EXT){1'b0}}, spi_addr};

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk    (clk),
      .reset  (reset),
      .en_i   (frame_active),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      bit_d   = bit_q;
      rd_d    = rd_q;
      sclk_d  = sclk_q;
      case (state_q)
         IDLE: begin
            if (spi_we || spi_re) begin
               rd_d    = !spi_we;
               tx_d    = build_frame(!spi_we, addr_ext, spi_din);
               bit_d   = '0;
               sclk_d  = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            // End of setup is the rising edge of bit 0.
            if (tick) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
               end else if (bit_q == LAST_BIT) begin
                  // Low phase of the last bit doubles as CS hold; data is
                  // published on entry to DONE so it is valid with spi_done.
                  state_d = DONE;
                  if (rd_q) begin
                     dout_d = rx_q;
                  end
               end else begin
                  bit_d  = bit_q + 1'b1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[DATA_WIDTH-2:0], miso};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         bit_q   <= '0;
         rd_q    <= 1'b0;
         sclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         bit_q   <= bit_d;
         rd_q    <= rd_d;
         sclk_q  <= sclk_d;
      end
   end

   assign spi_busy = frame_active;
   assign spi_done = (state_q == DONE);
   assign cs_n     = !frame_active;
   assign sclk     = sclk_q;
   assign mosi     = frame_active && tx_q[FRAME_BITS-1];
   assign spi_dout = dout_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge with a behavioural mode-0 SPI SRAM model.
// A second instance runs at CLK_DIV=1 for the fast-divider latency case.
module tb_spi_mem_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        spi_we = 1'b0, spi_re = 1'b0;
   logic [19:0] spi_addr = '0;
   logic [7:0]  spi_din = '0;
   logic [7:0]  spi_dout;
   logic        spi_busy, spi_done, sclk, cs_n, mosi, miso;

   logic        spi_we2 = 1'b0, spi_re2 = 1'b0;
   logic [19:0] spi_addr2 = '0;
   logic [7:0]  spi_din2 = '0;
   logic [7:0]  spi_dout2;
   logic        spi_busy2, spi_done2, sclk2, cs_n2, mosi2, miso2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   spi_mem_bridge #(.ADDR_WIDTH_EXT(20), .DATA_WIDTH(8), .CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .spi_we(spi_we), .spi_re(spi_re),
      .spi_addr(spi_addr), .spi_din(spi_din), .spi_dout(spi_dout),
      .spi_busy(spi_busy), .spi_done(spi_done), .sclk(sclk), .cs_n(cs_n),
      .mosi(mosi), .miso(miso)
   );

   spi_mem_bridge #(.ADDR_WIDTH_EXT(20), .DATA_WIDTH(8), .CLK_DIV(1)) dut2 (
      .clk(clk), .reset(reset), .spi_we(spi_we2), .spi_re(spi_re2),
      .spi_addr(spi_addr2), .spi_din(spi_din2), .spi_dout(spi_dout2),
      .spi_busy(spi_busy2), .spi_done(spi_done2), .sclk(sclk2), .cs_n(cs_n2),
      .mosi(mosi2), .miso(miso2)
   );

   // SRAM model: captures MOSI on rising SCLK, presents read data after falls.
   logic [7:0]  rbyte = 8'h00;
   logic [7:0]  rbyte2 = 8'h00;
   logic [39:0] mosi_sh = '0;
   int rise_cnt = 0, rise_base = 0, fall_cnt = 0, fall_base = 0;
   int fall2_cnt = 0, fall2_base = 0;

   always @(posedge sclk) begin
      rise_cnt <= rise_cnt + 1;
      mosi_sh  <= {mosi_sh[38:0], mosi};
   end
   always @(negedge sclk) fall_cnt <= fall_cnt + 1;
   always @(negedge cs_n) begin
      rise_base <= rise_cnt;
      fall_base <= fall_cnt;
   end
   always @(negedge sclk2) fall2_cnt <= fall2_cnt + 1;
   always @(negedge cs_n2) fall2_base <= fall2_cnt;

   always_comb begin
      int r;
      r    = fall_cnt - fall_base;
      miso = 1'b0;
      if (r >= 32 && r < 40) miso = rbyte[39-r];
   end
   always_comb begin
      int r2;
      r2    = fall2_cnt - fall2_base;
      miso2 = 1'b0;
      if (r2 >= 32 && r2 < 40) miso2 = rbyte2[39-r2];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic we, input logic re, input logic [19:0] addr,
                            input logic [7:0] din);
      @(negedge clk);
      spi_we = we; spi_re = re; spi_addr = addr; spi_din = din;
      @(posedge clk);
      #1;
      spi_we = 1'b0; spi_re = 1'b0;
   endtask

   // Cycle 1 is the cycle after the accept edge; returns the cycle of spi_done.
   task automatic wait_done(output int cyc, output int busy_cycles,
                            output logic cs_first, output logic [7:0] dout_at_done);
      cyc = -1; busy_cycles = 0; cs_first = 1'bx; dout_at_done = 'x;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (i == 1) cs_first = cs_n;
         if (spi_done) begin
            cyc = i;
            dout_at_done = spi_dout;
            break;
         end
         if (spi_busy) busy_cycles++;
      end
   endtask

   int          cyc, busy_n, hi, extra, reached;
   logic        cs_first;
   logic [7:0]  dd;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_busy", spi_busy, 1'b0);
      chk("rst_done", spi_done, 1'b0);
      chk("rst_dout", spi_dout, 8'h00);
      reset = 1'b0;

      // Write 12345 <- A5
      start_req(1'b1, 1'b0, 20'h12345, 8'hA5);
      wait_done(cyc, busy_n, cs_first, dd);
      $display("write addr=12345 din=a5: done_cycle=%0d mosi=%h rises=%0d", cyc, mosi_sh, rise_cnt - rise_base);
      chk("wr_latency", cyc, 163);
      chk("wr_busy_cycles", busy_n, 162);
      chk("wr_cs_low_setup", cs_first, 1'b0);
      chk("wr_mosi", mosi_sh, 40'h02_01_23_45_A5);
      chk("wr_rises", rise_cnt - rise_base, 40);
      chk("wr_dout", dd, 8'h00);
      @(negedge clk);
      chk("wr_done_one_cycle", spi_done, 1'b0);

      // Read FFFFF with SRAM returning 3C
      rbyte = 8'h3C;
      start_req(1'b0, 1'b1, 20'hFFFFF, 8'h99);
      wait_done(cyc, busy_n, cs_first, dd);
      $display("read addr=fffff: done_cycle=%0d mosi=%h dout=%h", cyc, mosi_sh, dd);
      chk("rd_latency", cyc, 163);
      chk("rd_mosi", mosi_sh, 40'h03_0F_FF_FF_00);
      chk("rd_dout_at_done", dd, 8'h3C);
      repeat (5) @(negedge clk);
      chk("rd_dout_held", spi_dout, 8'h3C);

      // Reset in the middle of a write frame, at bit 20
      start_req(1'b1, 1'b0, 20'h0F0F0, 8'h11);
      reached = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rise_cnt - rise_base >= 21) begin
            reached = 1;
            break;
         end
      end
      chk("mid_reach_bit20", reached, 1);
      #2 reset = 1'b1;
      #1;
      $display("reset mid-frame: cs_n=%b sclk=%b busy=%b dout=%h", cs_n, sclk, spi_busy, spi_dout);
      chk("mid_cs_n", cs_n, 1'b1);
      chk("mid_sclk", sclk, 1'b0);
      chk("mid_mosi", mosi, 1'b0);
      chk("mid_busy", spi_busy, 1'b0);
      chk("mid_done", spi_done, 1'b0);
      chk("mid_dout", spi_dout, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Write and read together: write wins; second pulse at bit 10 dropped
      start_req(1'b1, 1'b1, 20'h00ABC, 8'h5A);
      reached = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rise_cnt - rise_base >= 11) begin
            reached = 1;
            break;
         end
      end
      chk("both_reach_bit10", reached, 1);
      spi_re = 1'b1; spi_addr = 20'h55555;
      @(posedge clk);
      #1 spi_re = 1'b0;
      wait_done(cyc, busy_n, cs_first, dd);
      $display("we+re addr=00abc din=5a: done_cycle=%0d mosi=%h rises=%0d", cyc, mosi_sh, rise_cnt - rise_base);
      chk("both_mosi", mosi_sh, 40'h02_00_0A_BC_5A);
      chk("both_rises", rise_cnt - rise_base, 40);
      chk("both_dout", dd, 8'h00);
      extra = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (spi_done) extra++;
      end
      chk("both_extra_done", extra, 0);

      // Back-to-back reads
      rbyte = 8'hC5;
      start_req(1'b0, 1'b1, 20'h00001, 8'h00);
      wait_done(cyc, busy_n, cs_first, dd);
      $display("b2b read1 addr=00001: done_cycle=%0d dout=%h", cyc, dd);
      chk("b2b_first_dout", dd, 8'hC5);
      hi = cs_n ? 1 : 0;
      rbyte = 8'h6E;
      @(posedge clk);
      #1;
      spi_re = 1'b1; spi_addr = 20'hABCDE;
      @(negedge clk);
      if (cs_n) hi++;
      @(posedge clk);
      #1 spi_re = 1'b0;
      wait_done(cyc, busy_n, cs_first, dd);
      $display("b2b read2 addr=abcde: done_cycle=%0d mosi=%h dout=%h cs_high=%0d", cyc, mosi_sh, dd, hi);
      chk("b2b_cs_high", hi, 2);
      chk("b2b_cs_low_after", cs_first, 1'b0);
      chk("b2b_latency", cyc, 163);
      chk("b2b_mosi", mosi_sh, 40'h03_0A_BC_DE_00);
      chk("b2b_dout", dd, 8'h6E);

      // CLK_DIV=1 read of 81
      rbyte2 = 8'h81;
      @(negedge clk);
      spi_re2 = 1'b1; spi_addr2 = 20'h00042;
      @(posedge clk);
      #1 spi_re2 = 1'b0;
      cyc = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (spi_done2) begin
            cyc = i;
            dd = spi_dout2;
            break;
         end
      end
      $display("div1 read addr=00042: done_cycle=%0d dout=%h", cyc, dd);
      chk("div1_latency", cyc, 82);
      chk("div1_dout", dd, 8'h81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
